// File: rtl/bist_pkg.sv
// Shared definitions for the BIST run-control sequencer and controller.
// State encoding, default window lengths and signature width.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int INIT_CYCLES_DEF   = 2;
  localparam int PATTERN_COUNT_DEF = 8;
  localparam int CHECK_CYCLES_DEF  = 2;
  localparam int SIG_W             = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// Handshake/status bundle between the BIST sequencer and its host.
// master is the sequencer side, slave the host side.
interface bist_sequencer_if #(
  parameter int CNT_W = 8
);

  logic             bist_start;
  logic             bist_abort;
  logic             fault_detected;
  logic             testmode;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic             pass;
  logic             aborted;
  logic [CNT_W-1:0] run_count;
  logic [CNT_W-1:0] fail_count;

  modport master (
    input  bist_start, bist_abort, fault_detected,
    output testmode, core_reset, busy, done,
    output pass, aborted, run_count, fail_count
  );

  modport slave (
    output bist_start, bist_abort, fault_detected,
    input  testmode, core_reset, busy, done,
    input  pass, aborted, run_count, fail_count
  );

endinterface

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module bist_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// Run-control FSM in front of the BIST controller: start, timed windows,
// end-of-run fault sampling, sticky status and saturating counters.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int INIT_CYCLES   = INIT_CYCLES_DEF,
  parameter int PATTERN_COUNT = PATTERN_COUNT_DEF,
  parameter int CHECK_CYCLES  = CHECK_CYCLES_DEF,
  parameter int CNT_W         = 8
) (
  input logic              clock,
  input logic              reset,
  bist_sequencer_if.master bus
);

  localparam int CMAX = max3(INIT_CYCLES, PATTERN_COUNT, CHECK_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          active;
  logic          stop;
  logic          run_inc;
  logic          fail_inc;

  assign last     = (cnt == '0);
  assign active   = (state == INIT) || (state == RUN) || (state == CHECK);
  assign stop     = active && bus.bist_abort;
  assign run_inc  = (state == DONE);
  assign fail_inc = (state == CHECK) && last && !stop && bus.fault_detected;

  // Outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.testmode   <= 1'b0;
      bus.core_reset <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.aborted    <= 1'b0;
    end else begin
      bus.testmode   <= active;
      bus.core_reset <= (state == INIT);
      bus.busy       <= (state != IDLE);
      bus.done       <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.bist_start && !bus.bist_abort) begin
            state       <= INIT;
            cnt         <= CW'(INIT_CYCLES - 1);
            bus.pass    <= 1'b0;
            bus.aborted <= 1'b0;
          end
        end
        INIT: begin
          if (last) begin
            state <= RUN;
            cnt   <= CW'(PATTERN_COUNT - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RUN: begin
          if (last) begin
            state <= CHECK;
            cnt   <= CW'(CHECK_CYCLES - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CHECK: begin
          if (last) begin
            state    <= DONE;
            bus.pass <= !bus.fault_detected;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (stop) begin
        state          <= IDLE;
        cnt            <= '0;
        bus.testmode   <= 1'b0;
        bus.core_reset <= 1'b0;
        bus.busy       <= 1'b0;
        bus.pass       <= 1'b0;
        bus.aborted    <= 1'b1;
      end
    end
  end

  bist_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (run_inc),
    .count (bus.run_count)
  );

  bist_sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (fail_inc),
    .count (bus.fail_count)
  );

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: directed scenarios plus random traffic,
// all compared against a run-position reference model.
module tb_bist_sequencer;

  localparam int I   = 2;
  localparam int P   = 8;
  localparam int C   = 2;
  localparam int T   = I + P + C;
  localparam int MAX = 255;

  logic clock;
  logic reset;

  bist_sequencer_if #(.CNT_W(8)) bus ();

  bist_sequencer #(
    .INIT_CYCLES   (I),
    .PATTERN_COUNT (P),
    .CHECK_CYCLES  (C),
    .CNT_W         (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: a run is a position p counted in edges since the start edge.
  bit m_act;
  int m_pos;
  bit m_pass, m_abt;
  int m_run, m_fail;
  bit e_tm, e_cr, e_busy, e_done;

  task automatic model_clear();
    m_act = 0; m_pos = 0; m_pass = 0; m_abt = 0;
    m_run = 0; m_fail = 0;
    e_tm = 0; e_cr = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".testmode"}, int'(bus.testmode), int'(e_tm));
    chk({tag, ".core_reset"}, int'(bus.core_reset), int'(e_cr));
    chk({tag, ".busy"}, int'(bus.busy), int'(e_busy));
    chk({tag, ".done"}, int'(bus.done), int'(e_done));
    chk({tag, ".pass"}, int'(bus.pass), int'(m_pass));
    chk({tag, ".aborted"}, int'(bus.aborted), int'(m_abt));
    chk({tag, ".run_count"}, int'(bus.run_count), m_run);
    chk({tag, ".fail_count"}, int'(bus.fail_count), m_fail);
  endtask

  task automatic step(input string tag, input bit s, input bit a,
                      input bit f);
    bus.bist_start     = s;
    bus.bist_abort     = a;
    bus.fault_detected = f;
    @(posedge clock);
    e_tm = 0; e_cr = 0; e_busy = 0; e_done = 0;
    if (!m_act) begin
      if (s && !a) begin
        m_act = 1; m_pos = 0; m_pass = 0; m_abt = 0;
      end
    end else begin
      m_pos++;
      if (a && m_pos <= T) begin
        m_act = 0; m_abt = 1; m_pass = 0;
      end else begin
        e_tm   = (m_pos <= T);
        e_cr   = (m_pos <= I);
        e_busy = 1;
        e_done = (m_pos == T + 1);
        if (m_pos == T) begin
          m_pass = !f;
          if (f && m_fail < MAX) m_fail++;
        end
        if (m_pos == T + 1) begin
          m_act = 0;
          if (m_run < MAX) m_run++;
        end
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    bus.bist_start = 0; bus.bist_abort = 0; bus.fault_detected = 0;
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    model_clear();
    compare_all("reset");
    reset = 0;
  endtask

  int first_done;
  int ndone;
  int dq[$];

  initial begin
    reset = 0;
    bus.bist_start = 0; bus.bist_abort = 0; bus.fault_detected = 0;
    #1;
    do_reset();

    // passing run
    step("p0", 1, 0, 0);
    first_done = -1;
    for (int e = 1; e <= 15; e++) begin
      step("pass_run", 0, 0, 0);
      if (bus.done && first_done < 0) first_done = e;
    end
    chk("done_edge", first_done, 13);
    chk("pass_after_run", int'(bus.pass), 1);
    chk("run_after_pass", int'(bus.run_count), 1);
    chk("fail_after_pass", int'(bus.fail_count), 0);

    // failing run
    step("f0", 1, 0, 1);
    ndone = 0;
    for (int e = 1; e <= 15; e++) begin
      step("fail_run", 0, 0, 1);
      if (bus.done) ndone++;
    end
    chk("done_len", ndone, 1);
    chk("pass_after_fail", int'(bus.pass), 0);
    chk("fail_after_fail", int'(bus.fail_count), 1);
    chk("run_after_fail", int'(bus.run_count), 2);

    // abort during RUN at edge 5
    step("a0", 1, 0, 0);
    for (int e = 1; e <= 4; e++) step("abort_pre", 0, 0, 0);
    step("abort_e5", 0, 1, 0);
    step("abort_e6", 0, 0, 0);
    chk("abort_flag", int'(bus.aborted), 1);
    chk("abort_testmode", int'(bus.testmode), 0);
    chk("abort_busy", int'(bus.busy), 0);
    ndone = 0;
    for (int e = 7; e <= 16; e++) begin
      step("abort_post", 0, 0, 0);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_run_kept", int'(bus.run_count), 2);

    // start and abort together in IDLE
    step("both_idle", 1, 1, 0);
    chk("both_idle_busy", int'(bus.busy), 0);

    // start held: back-to-back runs
    do_reset();
    for (int e = 0; e <= 41; e++) begin
      step("b2b", 1, 0, 0);
      if (bus.done) dq.push_back(e);
    end
    for (int e = 0; e < 4; e++) step("b2b_tail", 0, 0, 0);
    chk("b2b_runs", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b_done0", dq[0], 13);
      chk("b2b_done1", dq[1], 27);
      chk("b2b_done2", dq[2], 41);
    end
    chk("b2b_run_count", int'(bus.run_count), 3);

    // async reset at edge 7, then a normal run
    step("r0", 1, 0, 0);
    for (int e = 1; e <= 7; e++) step("rst_pre", 0, 0, 0);
    #2 reset = 1;
    #1;
    model_clear();
    compare_all("async_reset");
    @(negedge clock);
    reset = 0;
    step("r_start", 1, 0, 0);
    first_done = -1;
    for (int e = 1; e <= 15; e++) begin
      step("rst_run", 0, 0, 0);
      if (bus.done && first_done < 0) first_done = e;
    end
    chk("rst_done_edge", first_done, 13);

    // saturation of both counters
    do_reset();
    for (int e = 0; e < 258 * (T + 2); e++) step("sat", 1, 0, 1);
    for (int e = 0; e < T + 4; e++) step("sat_tail", 0, 0, 0);
    chk("sat_fail", int'(bus.fail_count), 255);
    chk("sat_run", int'(bus.run_count), 255);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step("rand",
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Run-control FSM directly upstream of the BIST controller (LFSR -> full adder CUT -> 4-bit MISR -> golden-signature compare).
- Accepts a start request, then drives the controller's testmode and its LFSR/MISR reset.
- Times the pattern window, samples the controller's fault_detected at the end of the run, and reports pass/fail with sticky status and saturating run/fail counters.

Parameters:
- INIT_CYCLES, 2, cycles core_reset is held asserted before patterns start (min 1).
- PATTERN_COUNT, 8, cycles testmode stays high with core_reset low, covering the 3-bit LFSR sequence plus one MISR capture (min 1).
- CHECK_CYCLES, 2, cycles testmode stays high after the pattern window so fault_detected can register (min 1).
- CNT_W, 8, width of run_count and fail_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bist_start  in  1  level sampled in IDLE only; starts one run.
- bist_abort  in  1  cancels an active run.
- fault_detected  in  1  from the BIST controller.
- testmode  out  1  to the BIST controller.
- core_reset  out  1  reset for the controller's LFSR/MISR; the system ORs it with global reset.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  sticky result of the last completed run.
- aborted  out  1  sticky; last run was aborted.
- run_count  out  CNT_W  completed runs, saturating.
- fail_count  out  CNT_W  failed runs, saturating.

Behaviour:
- Reset (async, active-high): state=IDLE, all outputs 0, internal cycle counter 0.
- All outputs are registered; no combinational path from input to output.
- State IDLE:
  - testmode=0, core_reset=0, busy=0.
  - bist_start=1 and bist_abort=0 -> INIT. This clears pass and aborted and loads the cycle counter.
- State INIT:
  - testmode=1, core_reset=1.
  - Stays INIT_CYCLES cycles, then -> RUN.
- State RUN:
  - testmode=1, core_reset=0.
  - Stays PATTERN_COUNT cycles, then -> CHECK.
- State CHECK:
  - testmode=1, core_reset=0.
  - Stays CHECK_CYCLES cycles.
  - On the last CHECK cycle, samples fault_detected: pass <= !fault_detected.
  - If fault_detected=1, fail_count increments (saturating at all-ones).
  - Then -> DONE.
- State DONE:
  - done=1 for exactly one cycle, testmode=0.
  - run_count increments (saturating).
  - Then -> IDLE.
- Latency:
  - Call the clock edge that samples bist_start "edge 0".
  - done is high after edge INIT_CYCLES+PATTERN_COUNT+CHECK_CYCLES+1.
  - With defaults, done is high after edge 13; testmode is high after edges 1..12; core_reset is high after edges 1..2.
- bist_start while busy: ignored, no queuing.
- bist_start held high: a new run starts on the first IDLE cycle after DONE, i.e. back-to-back runs.
- bist_abort in INIT, RUN or CHECK:
  - Next state is IDLE; testmode=0, core_reset=0.
  - aborted=1, pass=0, no done pulse, counters unchanged.
- bist_abort in DONE: ignored; the run completes normally.
- bist_start and bist_abort both high in IDLE: abort wins; stays IDLE, aborted unchanged.
- reset mid-run: immediate return to IDLE with all outputs 0. Counters are lost.
- The cycle counter must be wide enough for max(INIT_CYCLES, PATTERN_COUNT, CHECK_CYCLES). It counts down and reloads on every state entry.

Decomposition:
- Package bist_pkg holds:
  - the state encoding (IDLE, INIT, RUN, CHECK, DONE, 3 bits);
  - default constants for INIT_CYCLES, PATTERN_COUNT and CHECK_CYCLES;
  - the golden signature width (4) for shared use with the controller.
- One sub-module: bist_sat_counter (CNT_W-wide saturating incrementer with async reset), instantiated twice, for run_count and fail_count.

Test Plan:
- Reset, then a bist_start pulse at edge 0 with fault_detected=0 -> done high after edge 13; pass=1, run_count=1, fail_count=0, testmode high over edges 1..12.
- Same run with fault_detected=1 during CHECK -> pass=0, fail_count=1, run_count=1, done pulse exactly one cycle.
- bist_abort asserted at edge 5 (RUN) -> IDLE after edge 6; testmode=0, aborted=1, no done pulse, run_count unchanged.
- bist_start held high for 40 cycles -> three complete runs (done after edges 13, 27, 41 if start is held through edge 28); run_count=3.
- Preload fail_count=255 (CNT_W=8) by forcing, then run a failing test -> fail_count stays 255; run_count increments.
- Assert reset at edge 7 mid-run -> all outputs 0 immediately (asynchronous), state IDLE; the next start gives a normal 13-cycle run.
